// File: rtl/rf_fft_bank.sv
// FFT register-file bank: multi-port word memory with bulk write and a
// handshaked bulk-read stream engine (natural or bit-reversed frame order).
module rf_fft_bank #(
  parameter int WORD_BITWIDTH  = 32,
  parameter int RF_DEPTH       = 128,
  parameter int WORDS_PER_BULK = 8,
  parameter int NUM_WORD_PORTS = 2,
  localparam int AW = $clog2(RF_DEPTH),
  localparam int BW = $clog2(RF_DEPTH / WORDS_PER_BULK),
  localparam int LW = $clog2(AW + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_WORD_PORTS-1:0]                word_w_en,
  input  logic [NUM_WORD_PORTS*AW-1:0]             word_w_addr,
  input  logic [NUM_WORD_PORTS*WORD_BITWIDTH-1:0]  word_w_data,
  input  logic [NUM_WORD_PORTS-1:0]                word_r_en,
  input  logic [NUM_WORD_PORTS*AW-1:0]             word_r_addr,
  output logic [NUM_WORD_PORTS*WORD_BITWIDTH-1:0]  word_r_data,
  input  logic                                     bulk_w_en,
  input  logic [BW-1:0]                            bulk_w_addr,
  input  logic [WORDS_PER_BULK*WORD_BITWIDTH-1:0]  bulk_w_data,
  input  logic                                     start,
  input  logic [LW-1:0]                            cfg_log2n,
  input  logic [AW-1:0]                            cfg_base,
  input  logic                                     cfg_bitrev,
  output logic                                     bo_valid,
  input  logic                                     bo_ready,
  output logic [WORDS_PER_BULK*WORD_BITWIDTH-1:0]  bo_data,
  output logic                                     bo_last,
  output logic                                     busy,
  output logic                                     cfg_err
);

  localparam int LOG2WPB = $clog2(WORDS_PER_BULK);
  localparam int KW      = (BW > 0) ? BW : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [WORD_BITWIDTH-1:0] mem [RF_DEPTH];

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, ld_k;
  logic [LW-1:0]            log2n_q, ld_log2n;
  logic [AW-1:0]            base_q, ld_base;
  logic                     bitrev_q, ld_bitrev;
  logic                     load, err_d, ld_last;
  logic [WORDS_PER_BULK*WORD_BITWIDTH-1:0] beat_data;
  logic [AW:0]              j, n_pts;
  logic [AW-1:0]            rev_full, idx;
  logic [LW-1:0]            shamt;

  // Bulk first, then word ports in ascending index: the last NBA to a word wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < RF_DEPTH; a++) mem[a] <= '0;
    end else begin
      if (bulk_w_en) begin
        for (int unsigned i = 0; i < WORDS_PER_BULK; i++)
          mem[(AW'(bulk_w_addr) << LOG2WPB) | AW'(i)] <= bulk_w_data[i*WORD_BITWIDTH +: WORD_BITWIDTH];
      end
      for (int unsigned p = 0; p < NUM_WORD_PORTS; p++) begin
        if (word_w_en[p])
          mem[word_w_addr[p*AW +: AW]] <= word_w_data[p*WORD_BITWIDTH +: WORD_BITWIDTH];
      end
    end
  end

  always_comb begin
    word_r_data = '0;
    for (int unsigned p = 0; p < NUM_WORD_PORTS; p++) begin
      if (word_r_en[p])
        word_r_data[p*WORD_BITWIDTH +: WORD_BITWIDTH] = mem[word_r_addr[p*AW +: AW]];
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    err_d     = 1'b0;
    ld_k      = k_q;
    ld_log2n  = log2n_q;
    ld_base   = base_q;
    ld_bitrev = bitrev_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_log2n != '0 && cfg_log2n <= LW'(AW)) begin
            state_d   = STREAM;
            load      = 1'b1;
            ld_k      = '0;
            ld_log2n  = cfg_log2n;
            ld_base   = cfg_base;
            ld_bitrev = cfg_bitrev;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (bo_ready) begin
          if (bo_last) begin
            state_d = IDLE;
          end else begin
            load = 1'b1;
            ld_k = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit reversal of the low log2n bits: reverse all AW bits, then shift down.
  always_comb begin
    beat_data = '0;
    j         = '0;
    rev_full  = '0;
    idx       = '0;
    n_pts     = (AW+1)'(1) << ld_log2n;
    shamt     = LW'(AW) - ld_log2n;
    for (int unsigned i = 0; i < WORDS_PER_BULK; i++) begin
      j = ((AW+1)'(ld_k) << LOG2WPB) | (AW+1)'(i);
      for (int unsigned b = 0; b < AW; b++) rev_full[b] = j[AW-1-b];
      idx = ld_base + (ld_bitrev ? (rev_full >> shamt) : j[AW-1:0]);
      if (j < n_pts)
        beat_data[i*WORD_BITWIDTH +: WORD_BITWIDTH] = mem[idx];
    end
    if (ld_log2n <= LW'(LOG2WPB))
      ld_last = 1'b1;
    else
      ld_last = ({1'b0, ld_k} == (((KW+1)'(1) << (ld_log2n - LW'(LOG2WPB))) - (KW+1)'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      log2n_q  <= '0;
      base_q   <= '0;
      bitrev_q <= 1'b0;
      bo_data  <= '0;
      bo_last  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_err <= err_d;
      if (load) begin
        k_q      <= ld_k;
        log2n_q  <= ld_log2n;
        base_q   <= ld_base;
        bitrev_q <= ld_bitrev;
        bo_data  <= beat_data;
        bo_last  <= ld_last;
      end else if (state_q == STREAM && state_d == IDLE) begin
        bo_last <= 1'b0;
      end
    end
  end

  assign bo_valid = (state_q == STREAM);
  assign busy     = (state_q == STREAM);

endmodule

// File: tb/tb_rf_fft_bank.sv
// Directed self-checking bench for rf_fft_bank (default parameters).
module tb_rf_fft_bank;

  localparam int W  = 32;
  localparam int AW = 7;
  localparam int BW = 4;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       word_w_en;
  logic [2*AW-1:0]  word_w_addr;
  logic [2*W-1:0]   word_w_data;
  logic [1:0]       word_r_en;
  logic [2*AW-1:0]  word_r_addr;
  logic [2*W-1:0]   word_r_data;
  logic             bulk_w_en;
  logic [BW-1:0]    bulk_w_addr;
  logic [8*W-1:0]   bulk_w_data;
  logic             start;
  logic [LW-1:0]    cfg_log2n;
  logic [AW-1:0]    cfg_base;
  logic             cfg_bitrev;
  logic             bo_valid;
  logic             bo_ready;
  logic [8*W-1:0]   bo_data;
  logic             bo_last;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;
  int unsigned lanes [8];

  rf_fft_bank #(.WORD_BITWIDTH(32), .RF_DEPTH(128), .WORDS_PER_BULK(8), .NUM_WORD_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .word_w_en(word_w_en), .word_w_addr(word_w_addr), .word_w_data(word_w_data),
    .word_r_en(word_r_en), .word_r_addr(word_r_addr), .word_r_data(word_r_data),
    .bulk_w_en(bulk_w_en), .bulk_w_addr(bulk_w_addr), .bulk_w_data(bulk_w_data),
    .start(start), .cfg_log2n(cfg_log2n), .cfg_base(cfg_base), .cfg_bitrev(cfg_bitrev),
    .bo_valid(bo_valid), .bo_ready(bo_ready), .bo_data(bo_data), .bo_last(bo_last),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack(input int unsigned l [8]);
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = l[i];
    return r;
  endfunction

  task automatic do_start(input int log2n, input int base, input logic bitrev);
    start      = 1'b1;
    cfg_log2n  = LW'(log2n);
    cfg_base   = AW'(base);
    cfg_bitrev = bitrev;
    tick();
    start = 1'b0;
  endtask

  task automatic read0(input int addr, input logic [31:0] exp, input string tag);
    word_r_en[0]     = 1'b1;
    word_r_addr[6:0] = AW'(addr);
    #1;
    check(tag, 256'(word_r_data[31:0]), 256'(exp));
  endtask

  initial begin
    int k;
    int cyc;
    logic [3:0] pat;
    rst_n = 1'b0;
    word_w_en = '0; word_w_addr = '0; word_w_data = '0;
    word_r_en = '0; word_r_addr = '0;
    bulk_w_en = 1'b0; bulk_w_addr = '0; bulk_w_data = '0;
    start = 1'b0; cfg_log2n = '0; cfg_base = '0; cfg_bitrev = 1'b0; bo_ready = 1'b0;
    #23;
    check("rst_valid", 256'(bo_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_err", 256'(cfg_err), 256'(0));
    check("rst_last", 256'(bo_last), 256'(0));
    check("rst_data", bo_data, 256'(0));
    check("rst_rdata", 256'(word_r_data), 256'(0));
    rst_n = 1'b1;
    tick();
    read0(5, 32'h0, "rst_mem5");
    word_r_en = '0;

    // mem[a] = a via bulk writes
    for (int r = 0; r < 16; r++) begin
      bulk_w_en   = 1'b1;
      bulk_w_addr = BW'(r);
      for (int i = 0; i < 8; i++) bulk_w_data[i*32 +: 32] = 32'(r*8 + i);
      tick();
    end
    bulk_w_en = 1'b0;
    read0(77, 32'd77, "fill_mem77");
    word_r_en = '0;

    // bit-reversed 16-point drain
    bo_ready = 1'b1;
    do_start(4, 0, 1'b1);
    lanes = '{0, 8, 4, 12, 2, 10, 6, 14};
    check("br_valid0", 256'(bo_valid), 256'(1));
    check("br_busy0", 256'(busy), 256'(1));
    check("br_beat0", bo_data, pack(lanes));
    check("br_last0", 256'(bo_last), 256'(0));
    tick();
    lanes = '{1, 9, 5, 13, 3, 11, 7, 15};
    check("br_beat1", bo_data, pack(lanes));
    check("br_last1", 256'(bo_last), 256'(1));
    tick();
    check("br_busy_end", 256'(busy), 256'(0));
    check("br_valid_end", 256'(bo_valid), 256'(0));
    tick();
    check("br_busy_end2", 256'(busy), 256'(0));

    // short frame with address wrap
    do_start(2, 126, 1'b1);
    lanes = '{126, 0, 127, 1, 0, 0, 0, 0};
    check("wrap_beat", bo_data, pack(lanes));
    check("wrap_last", 256'(bo_last), 256'(1));
    tick();
    check("wrap_idle", 256'(bo_valid), 256'(0));

    // natural order under backpressure, pattern 1,0,0,1 repeating
    bo_ready = 1'b0;
    do_start(5, 16, 1'b0);
    pat = 4'b1001;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 60) begin
      if (bo_valid) begin
        for (int i = 0; i < 8; i++) lanes[i] = 16 + 8*k + i;
        check($sformatf("bp_beat%0d_c%0d", k, cyc), bo_data, pack(lanes));
        check($sformatf("bp_last%0d_c%0d", k, cyc), 256'(bo_last), 256'(k == 3));
      end
      bo_ready = pat[cyc % 4];
      if (bo_valid && bo_ready) k++;
      tick();
      cyc++;
    end
    check("bp_beats", 256'(k), 256'(4));
    check("bp_idle", 256'(busy), 256'(0));
    bo_ready = 1'b0;

    // write conflict on word 9 plus bulk row 1
    word_w_en   = 2'b11;
    word_w_addr = {AW'(9), AW'(9)};
    word_w_data = {32'hBBBB, 32'hAAAA};
    bulk_w_en   = 1'b1;
    bulk_w_addr = BW'(1);
    bulk_w_data = {8{32'hCCCC}};
    read0(9, 32'd9, "wc_same_cycle");
    tick();
    word_w_en = '0;
    bulk_w_en = 1'b0;
    read0(9, 32'hBBBB, "wc_mem9");
    read0(8, 32'hCCCC, "wc_mem8");
    for (int a = 10; a < 16; a++) read0(a, 32'hCCCC, $sformatf("wc_mem%0d", a));
    read0(16, 32'd16, "wc_mem16");
    word_r_en = '0;

    // rejected start, then start ignored while busy
    do_start(0, 0, 1'b0);
    check("err_pulse", 256'(cfg_err), 256'(1));
    check("err_busy", 256'(busy), 256'(0));
    tick();
    check("err_clear", 256'(cfg_err), 256'(0));
    do_start(4, 0, 1'b0);
    do_start(2, 64, 1'b1);
    check("ign_err", 256'(cfg_err), 256'(0));
    lanes = '{0, 1, 2, 3, 4, 5, 6, 7};
    check("ign_beat0", bo_data, pack(lanes));
    check("ign_last0", 256'(bo_last), 256'(0));
    bo_ready = 1'b1;
    tick();
    lanes = '{32'hCCCC, 32'hBBBB, 32'hCCCC, 32'hCCCC, 32'hCCCC, 32'hCCCC, 32'hCCCC, 32'hCCCC};
    check("ign_beat1", bo_data, pack(lanes));
    check("ign_last1", 256'(bo_last), 256'(1));
    tick();
    check("ign_idle", 256'(busy), 256'(0));

    // reset mid-stream
    do_start(5, 0, 1'b0);
    tick();
    check("rs_busy_pre", 256'(busy), 256'(1));
    bo_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid", 256'(bo_valid), 256'(0));
    check("rs_busy", 256'(busy), 256'(0));
    check("rs_data", bo_data, 256'(0));
    read0(3, 32'h0, "rs_mem3");
    read0(9, 32'h0, "rs_mem9");
    word_r_en = '0;
    #1;
    rst_n = 1'b1;
    tick();
    bo_ready = 1'b1;
    do_start(3, 0, 1'b1);
    check("rs2_valid", 256'(bo_valid), 256'(1));
    check("rs2_data", bo_data, 256'(0));
    check("rs2_last", 256'(bo_last), 256'(1));
    tick();
    check("rs2_idle", 256'(busy), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
